// File: rtl/rob_alloc_retire.sv
// Reorder-buffer bookkeeping: in-order allocation, writeback completion
// tracking and in-order retirement of up to MACHINE_WIDTH entries per cycle.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   alloc_valid/_dst    per-slot allocation requests (slot 0 oldest)
//   alloc_ready/_addr   room for a full group / granted ROB addresses
//   wb_valid/_addr      completion strobes per writeback port
//   retire_valid/_id/_preg  in-order retire pairs (arch dst, ROB addr)
//   flush               discard every entry
//   count               occupied entries
module rob_alloc_retire #(
  parameter int MACHINE_WIDTH = 2,
  parameter int WB_PORTS      = 2,
  parameter int ROB_DEPTH     = 16,
  parameter int ADDR_W        = 4,
  parameter int AREG_W        = 5
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [MACHINE_WIDTH-1:0]              alloc_valid,
  input  logic [MACHINE_WIDTH-1:0][AREG_W-1:0]  alloc_dst,
  output logic                                  alloc_ready,
  output logic [MACHINE_WIDTH-1:0][ADDR_W-1:0]  alloc_addr,
  input  logic [WB_PORTS-1:0]                   wb_valid,
  input  logic [WB_PORTS-1:0][ADDR_W-1:0]       wb_addr,
  output logic [MACHINE_WIDTH-1:0]              retire_valid,
  output logic [MACHINE_WIDTH-1:0][AREG_W-1:0]  retire_id,
  output logic [MACHINE_WIDTH-1:0][ADDR_W-1:0]  retire_preg,
  input  logic                                  flush,
  output logic [ADDR_W:0]                       count
);

  localparam logic [ADDR_W+1:0] DEPTH_W = (ADDR_W+2)'(ROB_DEPTH);
  localparam logic [ADDR_W+1:0] MW_W    = (ADDR_W+2)'(MACHINE_WIDTH);

  logic [ADDR_W:0]                  head_q, head_d;
  logic [ADDR_W:0]                  tail_q, tail_d;
  logic [ROB_DEPTH-1:0]             valid_q, valid_d;
  logic [ROB_DEPTH-1:0]             done_q, done_d;
  logic [ROB_DEPTH-1:0][AREG_W-1:0] dst_q, dst_d;

  logic [ADDR_W+1:0] free;
  logic [ADDR_W:0]   n_alloc;
  logic [ADDR_W:0]   n_ret;
  logic              alloc_acc;
  logic [MACHINE_WIDTH-1:0][ADDR_W-1:0] ret_idx;

  // Occupancy and readiness come from registered state only, so
  // alloc_ready never sees same-cycle retires.
  always_comb begin
    count       = tail_q - head_q;
    free        = DEPTH_W - {1'b0, count};
    alloc_ready = (free >= MW_W);
    alloc_acc   = alloc_ready & ~flush;
  end

  // Valid slots are packed onto consecutive addresses from tail.
  always_comb begin
    n_alloc    = '0;
    alloc_addr = '0;
    for (int i = 0; i < MACHINE_WIDTH; i++) begin
      alloc_addr[i] = tail_q[ADDR_W-1:0] + n_alloc[ADDR_W-1:0];
      if (alloc_valid[i]) n_alloc = n_alloc + 1'b1;
    end
  end

  // Retire is a prefix chain from head; reset and flush silence it.
  always_comb begin
    logic chain;
    chain        = ~flush & ~reset;
    n_ret        = '0;
    retire_valid = '0;
    retire_id    = '0;
    retire_preg  = '0;
    ret_idx      = '0;
    for (int i = 0; i < MACHINE_WIDTH; i++) begin
      ret_idx[i]      = head_q[ADDR_W-1:0] + ADDR_W'(i);
      chain           = chain & valid_q[ret_idx[i]] & done_q[ret_idx[i]];
      retire_valid[i] = chain;
      retire_id[i]    = dst_q[ret_idx[i]];
      retire_preg[i]  = ret_idx[i];
      if (chain) n_ret = n_ret + 1'b1;
    end
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    valid_d = valid_q;
    done_d  = done_q;
    dst_d   = dst_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      valid_d = '0;
      done_d  = '0;
    end else begin
      for (int p = 0; p < WB_PORTS; p++) begin
        if (wb_valid[p] && valid_q[wb_addr[p]]) done_d[wb_addr[p]] = 1'b1;
      end
      for (int i = 0; i < MACHINE_WIDTH; i++) begin
        if (retire_valid[i]) begin
          valid_d[ret_idx[i]] = 1'b0;
          done_d[ret_idx[i]]  = 1'b0;
        end
      end
      head_d = head_q + n_ret;
      if (alloc_acc) begin
        for (int i = 0; i < MACHINE_WIDTH; i++) begin
          if (alloc_valid[i]) begin
            valid_d[alloc_addr[i]] = 1'b1;
            done_d[alloc_addr[i]]  = 1'b0;
            dst_d[alloc_addr[i]]   = alloc_dst[i];
          end
        end
        tail_d = tail_q + n_alloc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      valid_q <= '0;
      done_q  <= '0;
      dst_q   <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      dst_q   <= dst_d;
    end
  end

endmodule
